// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl -- multi-cycle control sequencer for the RV32I core.
//
// Each instruction is stepped through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The shared instruction/data memory port is driven through a req/ack
// handshake, and the datapath (PC, IR, register file, IMMGEN, ALU, branch
// comparator) is steered through the strobes and mux selects below.
//
// Optional feature: define RV32I_CTRL_ILLEGAL_TRAP_EN to trap unlisted
// opcodes into an absorbing TRAP state that raises `illegal`. Without it,
// unlisted opcodes retire as a NOP and `illegal` is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   instr      in   IR contents, valid from DECODE until retirement
//   br_taken   in   branch comparator result, sampled in EXEC
//   mem_ack    in   memory completes the current request this cycle
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  store request (MEM state, STORE only)
//   mem_fetch  out  request is an instruction fetch
//   ir_we      out  load IR from memory read data
//   pc_we      out  update PC
//   pc_sel     out  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
//   immsel     out  0 = U, 1 = J, 2 = I, 3 = B, 4 = S, 5 = zero
//   alu_a_sel  out  0 = rs1, 1 = PC
//   alu_b_sel  out  0 = rs2, 1 = imm
//   rf_we      out  register-file write
//   wb_sel     out  0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm
//   illegal    out  illegal-opcode flag
//   state      out  current state (debug)
//   instret    out  retired-instruction counter (wraps)

module rv32i_mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  immsel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] instret_q;
  logic        retire;

  logic [6:0]  opc;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_opimm, is_op, is_wb_path;
  logic [2:0]  dec_immsel;
  logic        dec_a, dec_b;
  logic [1:0]  dec_wb;

  // Only the opcode field steers the sequencer; the rest of the IR feeds
  // the datapath directly.
  logic        unused_instr;
  assign unused_instr = ^instr[31:7];

  assign opc        = instr[6:0];
  assign is_lui     = (opc == OPC_LUI);
  assign is_auipc   = (opc == OPC_AUIPC);
  assign is_jal     = (opc == OPC_JAL);
  assign is_jalr    = (opc == OPC_JALR);
  assign is_branch  = (opc == OPC_BRANCH);
  assign is_load    = (opc == OPC_LOAD);
  assign is_store   = (opc == OPC_STORE);
  assign is_opimm   = (opc == OPC_OPIMM);
  assign is_op      = (opc == OPC_OP);
  assign is_wb_path = is_lui | is_auipc | is_jal | is_jalr | is_opimm | is_op;

  // Decoded selects. FENCE, SYSTEM and anything unlisted fall into the
  // default row: zero immediate, a = rs1, b = imm, ALU writeback.
  always_comb begin
    dec_immsel = 3'd5;
    dec_a      = 1'b0;
    dec_b      = 1'b1;
    dec_wb     = 2'd0;
    case (opc)
      OPC_LUI:    begin dec_immsel = 3'd0; dec_wb = 2'd3; end
      OPC_AUIPC:  begin dec_immsel = 3'd0; dec_a  = 1'b1; end
      OPC_JAL:    begin dec_immsel = 3'd1; dec_a  = 1'b1; dec_wb = 2'd2; end
      OPC_JALR:   begin dec_immsel = 3'd2; dec_wb = 2'd2; end
      OPC_BRANCH: begin dec_immsel = 3'd3; dec_a  = 1'b1; end
      OPC_LOAD:   begin dec_immsel = 3'd2; dec_wb = 2'd1; end
      OPC_STORE:  begin dec_immsel = 3'd4; end
      OPC_OPIMM:  begin dec_immsel = 3'd2; end
      OPC_OP:     begin dec_b      = 1'b0; end
      default:    ;
    endcase
  end

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  logic is_legal;
  logic illegal_q;
  logic set_illegal;
  assign is_legal = is_wb_path | is_branch | is_load | is_store |
                    (opc == OPC_FENCE) | (opc == OPC_SYSTEM);
`endif

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_fetch = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    immsel    = 3'd5;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    rf_we     = 1'b0;
    retire    = 1'b0;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    set_illegal = 1'b0;
`endif

    // Decoded selects are live from DECODE until the instruction retires;
    // the IR is stable over that whole window.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      immsel    = dec_immsel;
      alu_a_sel = dec_a;
      alu_b_sel = dec_b;
      wb_sel    = dec_wb;
    end

    case (state_q)
      S_FETCH: begin
        // run_q keeps the port idle for the first cycle after reset, so a
        // reset always drops mem_req on the following cycle.
        if (run_q) begin
          mem_req   = 1'b1;
          mem_fetch = 1'b1;
          if (mem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
        if (!is_legal) begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_wb_path) begin
          state_d = S_WB;
        end else begin
          // FENCE, SYSTEM and (without the trap) unlisted opcodes.
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (set_illegal) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Testbench for rv32i_mc_ctrl: random instruction stream with random memory
// latencies, checked by a scoreboard against a table-driven reference model.

module tb_rv32i_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        br_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_fetch, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  immsel;
  logic        alu_a_sel, alu_b_sel, rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  rv32i_mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .br_taken  (br_taken),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_fetch (mem_fetch),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .immsel    (immsel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .state     (state),
    .instret   (instret)
  );

  typedef struct {
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic [1:0] wbs;
    logic [1:0] psel;
    logic       rf;
    logic       mem;
    logic       store;
    logic [2:0] rstate;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [6:0]  ops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the retiring instruction must look like, from the
  // opcode tables and latency rules (one cycle per state, plus ack waits).
  function automatic exp_t model(input logic [31:0] ins, input logic br,
                                 input int df, input int dm);
    exp_t e;
    e.imm = 3'd5; e.a = 1'b0; e.b = 1'b1; e.wbs = 2'd0; e.psel = 2'd0;
    e.rf = 1'b0; e.mem = 1'b0; e.store = 1'b0; e.rstate = 3'd2; e.cyc = 3;
    case (ins[6:0])
      7'h37: begin e.imm = 3'd0; e.wbs = 2'd3; e.rf = 1'b1; end
      7'h17: begin e.imm = 3'd0; e.a = 1'b1; e.rf = 1'b1; end
      7'h6F: begin e.imm = 3'd1; e.a = 1'b1; e.wbs = 2'd2; e.psel = 2'd1; e.rf = 1'b1; end
      7'h67: begin e.imm = 3'd2; e.wbs = 2'd2; e.psel = 2'd2; e.rf = 1'b1; end
      7'h63: begin e.imm = 3'd3; e.a = 1'b1; e.psel = br ? 2'd1 : 2'd0; end
      7'h03: begin e.imm = 3'd2; e.wbs = 2'd1; e.rf = 1'b1; e.mem = 1'b1; end
      7'h23: begin e.imm = 3'd4; e.mem = 1'b1; e.store = 1'b1; e.rstate = 3'd3; e.cyc = 4; end
      7'h13: begin e.imm = 3'd2; e.rf = 1'b1; end
      7'h33: begin e.b = 1'b0; e.rf = 1'b1; end
      default: ;
    endcase
    if (e.rf) begin
      e.rstate = 3'd4;
      e.cyc    = e.mem ? 5 : 4;
    end
    e.cyc = e.cyc + df + (e.mem ? dm : 0);
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge where the wanted
  // request is visible. Acks driven while no request is up are random noise.
  task automatic find_req(input logic fetch, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (mem_req && (mem_fetch == fetch)) begin
        ok = 1'b1;
        break;
      end
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk(fetch ? "fetch_req_seen" : "data_req_seen", 32'(ok), 32'd1);
  endtask

  task automatic ack_after(input int d);
    for (int i = 0; i < d; i++) begin
      mem_ack = 1'b0;
      @(negedge clk);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic br, input int df, input int dm);
    bit   ok;
    exp_t e;
    find_req(1'b1, ok);
    if (!ok) return;
    instr    = ins;
    br_taken = br;
    e = model(ins, br, df, dm);
    exp_q.push_back(e);
    ack_after(df);
    if (e.mem) begin
      find_req(1'b0, ok);
      if (!ok) return;
      ack_after(dm);
    end
  endtask

  task automatic drain();
    int t = 0;
    mem_ack = 1'b0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: per-cycle invariants, and on every retire (pc_we) pop and compare.
  initial begin
    bit   in_i = 1'b0;
    int   cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        in_i = 1'b0;
        cnt = 0;
        exp_instret = 32'd0;
        exp_q.delete();
        continue;
      end
      chk("strobe_invariants",
          {28'd0,
           rf_we && !pc_we,
           mem_we && (!mem_req || mem_fetch),
           ir_we && !(mem_req && mem_fetch && mem_ack),
           pc_we && rf_we && (state != 3'd4)},
          32'd0);
      if (!in_i && mem_req && mem_fetch) begin
        in_i = 1'b1;
        cnt = 0;
      end
      if (in_i) cnt++;
      if (mem_req && !mem_fetch && exp_q.size() > 0)
        chk("mem_we", 32'(mem_we), 32'(exp_q[0].store));
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: pc_we=1, expected no retire at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pc_sel", 32'(pc_sel), 32'(e.psel));
          chk("rf_we", 32'(rf_we), 32'(e.rf));
          chk("wb_sel", 32'(wb_sel), 32'(e.wbs));
          chk("immsel", 32'(immsel), 32'(e.imm));
          chk("alu_a_sel", 32'(alu_a_sel), 32'(e.a));
          chk("alu_b_sel", 32'(alu_b_sel), 32'(e.b));
          chk("retire_state", 32'(state), 32'(e.rstate));
          chk("latency", 32'(cnt), 32'(e.cyc));
          chk("instret", instret, exp_instret);
          exp_instret = exp_instret + 32'd1;
        end
        in_i = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] frozen;
    bit          ok;

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
`ifndef RV32I_CTRL_ILLEGAL_TRAP_EN
    ops.push_back(7'h7F);
    ops.push_back(7'h0B);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_strobes", {27'd0, ir_we, pc_we, rf_we, mem_req, mem_we}, 32'd0);
    chk("rst_immsel", 32'(immsel), 32'd5);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence.
    issue(32'h00500093, 1'b0, 0, 0);   // ADDI x1,x0,5
    issue(32'h00000463, 1'b1, 0, 0);   // BEQ taken
    issue(32'h0000A103, 1'b0, 0, 3);   // LW, data ack delayed 3
    issue(32'h0020A023, 1'b0, 1, 0);   // SW
    issue(32'h000080E7, 1'b0, 0, 0);   // JALR
    issue(32'h123450B7, 1'b0, 0, 0);   // LUI
`ifndef RV32I_CTRL_ILLEGAL_TRAP_EN
    issue(32'h0000007F, 1'b0, 0, 0);   // unlisted opcode -> NOP
`endif

    // Random stream.
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      issue({r[31:7], ops[$urandom_range(0, ops.size() - 1)]},
            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();
    chk("instret_total", instret, exp_instret);

    // Reset in the middle of a stalled load.
    find_req(1'b1, ok);
    instr = 32'h0000A103;
    ack_after(0);
    find_req(1'b0, ok);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      r = $urandom();
      issue({r[31:7], ops[$urandom_range(0, ops.size() - 1)]},
            1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    drain();
    chk("instret_after_rst", instret, exp_instret);

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps and holds until reset.
    find_req(1'b1, ok);
    instr = 32'h0000007F;
    ack_after(0);
    @(negedge clk);
    frozen = exp_instret;
    for (int i = 0; i < 10; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state", 32'(state), 32'd5);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_strobes", {27'd0, ir_we, pc_we, rf_we, mem_req, mem_we}, 32'd0);
      chk("trap_instret", instret, frozen);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    chk("trap_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h00500093, 1'b0, 0, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
